// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin selection among ALU/BRU/LSU result streams
// into a single registered output stage that drives the register-file write port.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NSRC = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NSRC-1:0]            src_tvalid,
    output logic [NSRC-1:0]            src_tready,
    input  logic [NSRC-1:0][XLEN+4:0]  src_tdata,
    input  logic                       rf_wstall,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic                       sb_clr_valid,
    output logic [63:0]                instret,
    input  logic                       invalidate
);

    typedef logic [1:0] src_idx_t;

    function automatic src_idx_t next_src(input src_idx_t idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    logic            out_valid_q, out_valid_d;
    logic [4:0]      out_rd_q,    out_rd_d;
    logic [XLEN-1:0] out_data_q,  out_data_d;
    src_idx_t        rr_q,        rr_d;
    logic [63:0]     instret_q,   instret_d;
    logic            rst_q,       rst_d;

    src_idx_t grant_s;
    src_idx_t cand_s;
    logic     grant_found_s;
    logic     retire_s;
    logic     free_s;
    logic     accept_s;

    // Cyclic scan for the first valid source starting at the round-robin pointer.
    always_comb begin
        grant_s       = rr_q;
        grant_found_s = 1'b0;
        cand_s        = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!grant_found_s && src_tvalid[cand_s]) begin
                grant_s       = cand_s;
                grant_found_s = 1'b1;
            end else begin
                grant_found_s = grant_found_s;
            end
            cand_s = next_src(cand_s);
        end
    end

    // Handshake qualifiers; ready is also held low the cycle after reset.
    always_comb begin
        retire_s = out_valid_q && !rf_wstall && !invalidate && !rst;
        free_s   = !out_valid_q || retire_s;
        accept_s = grant_found_s && free_s && !invalidate && !rst && !rst_q;
        if (accept_s) begin
            src_tready = NSRC'(1) << grant_s;
        end else begin
            src_tready = '0;
        end
    end

    // Register-file write port and scoreboard clear straight from the output stage.
    always_comb begin
        rf_we        = retire_s && (out_rd_q != 5'd0);
        sb_clr_valid = retire_s;
        instret      = instret_q;
        if (rst) begin
            rf_waddr = 5'd0;
            rf_wdata = '0;
        end else begin
            rf_waddr = out_rd_q;
            rf_wdata = out_data_q;
        end
    end

    // Next-state for the output stage, round-robin pointer and retire counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        rr_d        = rr_q;
        instret_d   = instret_q;
        rst_d       = rst;
        if (retire_s) begin
            instret_d = instret_q + 64'd1;
        end else begin
            instret_d = instret_q;
        end
        if (invalidate) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_rd_d    = src_tdata[grant_s][XLEN+4:XLEN];
            out_data_d  = src_tdata[grant_s][XLEN-1:0];
            rr_d        = next_src(grant_s);
        end else if (retire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        rst_q <= rst_d;
        if (rst) begin
            out_valid_q <= 1'b0;
            out_rd_q    <= 5'd0;
            out_data_q  <= '0;
            rr_q        <= 2'd0;
            instret_q   <= 64'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            rr_q        <= rr_d;
            instret_q   <= instret_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a cycle model predicts grants and pushes
// accepted entries into a scoreboard that is popped on every observed retire.
module tb_wb_arbiter;

    localparam int XLEN = 32;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0]           src_tvalid;
    logic [2:0]           src_tready;
    logic [2:0][36:0]     src_tdata;
    logic                 rf_wstall;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic                 sb_clr_valid;
    logic [63:0]          instret;
    logic                 invalidate;

    int n_vec = 0;
    int n_err = 0;

    ent_t        sbq[$];
    logic        m_valid;
    int          m_rr;
    logic [63:0] m_inst;
    logic        m_rstd;

    wb_arbiter #(.XLEN(XLEN), .NSRC(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_tvalid   (src_tvalid),
        .src_tready   (src_tready),
        .src_tdata    (src_tdata),
        .rf_wstall    (rf_wstall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .sb_clr_valid (sb_clr_valid),
        .instret      (instret),
        .invalidate   (invalidate)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_src(input int s, input logic v, input logic [4:0] rd, input logic [31:0] d);
        src_tvalid[s] = v;
        src_tdata[s]  = {rd, d};
    endtask

    // One cycle: check outputs against the model, then advance the model at the edge.
    task automatic step();
        logic       m_retire, m_acc;
        int         g;
        logic [2:0] exp_rdy;
        ent_t       e;
        #1;
        m_retire = m_valid && !rf_wstall && !invalidate && !rst;
        g        = -1;
        for (int k = 0; k < 3; k++) begin
            if (g < 0 && src_tvalid[(m_rr + k) % 3]) g = (m_rr + k) % 3;
        end
        m_acc   = (g >= 0) && (!m_valid || m_retire) && !invalidate && !rst && !m_rstd;
        exp_rdy = m_acc ? (3'b001 << g) : 3'b000;
        check_val("tready", {61'd0, src_tready}, {61'd0, exp_rdy});
        check_val("sb_clr", {63'd0, sb_clr_valid}, {63'd0, m_retire});
        check_val("instret", instret, m_inst);
        check_val("out_valid", {63'd0, dut.out_valid_q}, {63'd0, m_valid});
        check_val("rr", {62'd0, dut.rr_q}, 64'(m_rr));
        if (rst) begin
            check_val("rst_waddr", {59'd0, rf_waddr}, 64'd0);
            check_val("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        end else if (m_valid && sbq.size() > 0) begin
            check_val("waddr_hold", {59'd0, rf_waddr}, {59'd0, sbq[0].rd});
        end
        if (m_retire) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sbq_empty: retire seen with no expected entry at %0t", $time);
            end else begin
                e = sbq.pop_front();
                check_val("rf_we", {63'd0, rf_we}, {63'd0, (e.rd != 5'd0)});
                check_val("waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
                check_val("wdata", {32'd0, rf_wdata}, {32'd0, e.data});
            end
        end else begin
            check_val("rf_we_idle", {63'd0, rf_we}, 64'd0);
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_rr    = 0;
            m_inst  = 64'd0;
            sbq.delete();
        end else begin
            if (m_retire) m_inst = m_inst + 64'd1;
            if (invalidate) begin
                m_valid = 1'b0;
                sbq.delete();
            end else if (m_acc) begin
                e.rd   = src_tdata[g][36:32];
                e.data = src_tdata[g][31:0];
                sbq.push_back(e);
                m_valid = 1'b1;
                m_rr    = (g + 1) % 3;
            end else if (m_retire) begin
                m_valid = 1'b0;
            end
        end
        m_rstd = rst;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic idle_inputs();
        src_tvalid = 3'b000;
        rf_wstall  = 1'b0;
        invalidate = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        src_tdata  = '0;
        idle_inputs();
        rst        = 1'b1;
        m_valid    = 1'b0;
        m_rr       = 0;
        m_inst     = 64'd0;
        m_rstd     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run(2);

        // Single LSU result.
        rst = 1'b0;
        run(1);
        set_src(2, 1'b1, 5'd5, 32'hDEADBEEF);
        run(1);
        set_src(2, 1'b0, 5'd0, 32'd0);
        run(3);

        // All sources valid straight out of reset: strict rotation.
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < 3; s++) set_src(s, 1'b1, 5'(s + 1 + i), 32'(i * 16 + s));
            step();
        end
        src_tvalid = 3'b000;
        run(2);

        // x0 destination: no write, still clears scoreboard and counts.
        set_src(0, 1'b1, 5'd0, 32'h0000_1234);
        run(1);
        src_tvalid = 3'b000;
        run(2);

        // Stall with a pending rd=7 entry while BRU waits.
        set_src(0, 1'b1, 5'd7, 32'hCAFE_0007);
        run(1);
        set_src(0, 1'b0, 5'd0, 32'd0);
        set_src(1, 1'b1, 5'd9, 32'h0000_0009);
        rf_wstall = 1'b1;
        run(3);
        rf_wstall = 1'b0;
        run(1);
        src_tvalid = 3'b000;
        run(2);

        // Flush with stall and a competing BRU request in the same cycle.
        set_src(2, 1'b1, 5'd11, 32'h0000_00BB);
        run(1);
        set_src(2, 1'b0, 5'd0, 32'd0);
        set_src(1, 1'b1, 5'd12, 32'h0000_00CC);
        rf_wstall  = 1'b1;
        invalidate = 1'b1;
        run(1);
        idle_inputs();
        run(2);

        // Counter wrap from all ones.
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        m_inst = 64'hFFFF_FFFF_FFFF_FFFF;
        set_src(0, 1'b1, 5'd3, 32'h0000_0333);
        run(1);
        src_tvalid = 3'b000;
        run(2);

        // Reset with an entry in flight must not write it.
        set_src(1, 1'b1, 5'd4, 32'h0000_0444);
        run(1);
        src_tvalid = 3'b000;
        rst        = 1'b1;
        run(1);
        rst = 1'b0;
        run(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < 3; s++) set_src(s, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
            rf_wstall  = ($urandom_range(0, 3) == 0);
            invalidate = ($urandom_range(0, 19) == 0);
            rst        = ($urandom_range(0, 49) == 0);
            step();
        end
        idle_inputs();
        run(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/result width.
REQ-002 SHALL have parameter NSRC, fixed value 3, number of write-back sources (0=ALU, 1=BRU, 2=LSU).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have src_tvalid  input  NSRC  per-source AXIS valid.
REQ-006 SHALL have src_tready  output  NSRC  per-source AXIS ready.
REQ-007 SHALL have src_tdata  input  NSRC x (XLEN+5)  per-source payload: bits [XLEN+4:XLEN] = rd, bits [XLEN-1:0] = result.
REQ-008 SHALL have rf_wstall  input  1  register-file write port held by another agent this cycle.
REQ-009 SHALL have rf_we  output  1  register-file write enable.
REQ-010 SHALL have rf_waddr  output  5  register-file write index.
REQ-011 SHALL have rf_wdata  output  XLEN  register-file write data.
REQ-012 SHALL have sb_clr_valid  output  1  scoreboard clear strobe for rf_waddr.
REQ-013 SHALL have instret  output  64  retired-instruction count.
REQ-014 SHALL have invalidate  input  1  pipeline flush.

Function
REQ-015 SHALL hold one output stage: out_valid_q, out_rd_q, out_data_q.
REQ-016 SHALL define retire = out_valid_q && !rf_wstall && !invalidate.
REQ-017 SHALL define free = !out_valid_q || retire.
REQ-018 SHALL grant, combinationally, the first source with tvalid=1 found scanning cyclically from rr_q (rr_q, rr_q+1, ... mod 3).
REQ-019 SHALL drive src_tready[g]=1 only for granted g, and only when free && !invalidate; all other tready=0.
REQ-020 SHALL keep src_tready independent of the granted source's tready feedback (no tready->tvalid loop); tready may depend on tvalid.
REQ-021 SHALL, on accept (tvalid && tready for g), load out_rd_q/out_data_q from src_tdata[g], set out_valid_q=1 next cycle, and set rr_q = (g+1) mod 3.
REQ-022 SHALL leave rr_q unchanged in cycles with no accept.
REQ-023 SHALL clear out_valid_q on retire when no new accept occurs in that cycle; back-to-back accept+retire keeps out_valid_q=1 (throughput one per cycle).
REQ-024 SHALL hold out_* unchanged while out_valid_q && rf_wstall && !invalidate.
REQ-025 SHALL drive rf_we = retire && (out_rd_q != 0); x0 writes are suppressed.
REQ-026 SHALL drive rf_waddr = out_rd_q and rf_wdata = out_data_q at all times.
REQ-027 SHALL drive sb_clr_valid = retire, including when rd=0.
REQ-028 SHALL increment instret by 1 on each retire cycle, wrapping from 2^64-1 to 0.
REQ-029 SHALL, when invalidate=1, clear out_valid_q next cycle, accept nothing, and assert no rf_we/sb_clr_valid; invalidate overrides rf_wstall.
REQ-030 SHALL give latency of exactly 1 cycle from accept to rf_we when rf_wstall=0.

Reset
REQ-031 SHALL, on rst=1 at a rising edge, set out_valid_q=0, out_rd_q=0, out_data_q=0, rr_q=0, instret=0.
REQ-032 SHALL drive src_tready=0, rf_we=0, sb_clr_valid=0, rf_waddr=0, rf_wdata=0 during and the cycle after reset.
REQ-033 SHALL discard any in-flight output entry on reset mid-operation without writing it.

Verification
REQ-034 Single LSU result rd=5, result=0xDEADBEEF at cycle N -> src_tready[2]=1 at N; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, sb_clr_valid=1 at N+1; instret=1 at N+2.
REQ-035 All three tvalid held high for 6 cycles from reset -> grant order ALU, BRU, LSU, ALU, BRU, LSU; one rf_we per cycle from cycle 2 onward.
REQ-036 rd=0 result=0x1234 from ALU -> rf_we=0, sb_clr_valid=1, instret increments by 1.
REQ-037 Entry rd=7 pending, rf_wstall=1 for 3 cycles -> rf_we=0, all src_tready=0, rf_waddr=7 held; rf_we=1 in first cycle after rf_wstall drops.
REQ-038 Entry pending plus BRU tvalid=1, invalidate=1 with rf_wstall=1 in same cycle -> no rf_we, src_tready=0, out_valid_q=0 next cycle, rr_q unchanged, instret unchanged.
REQ-039 instret preloaded (force) to 0xFFFFFFFFFFFFFFFF, one retire -> instret=0.
